sram_arbiter: RTL and testbench

SRAM_ARBITER -- requirements
Module: sram_arbiter

---
 rtl/sram_arbiter_if.sv | 27 ++
 rtl/sram_arbiter.sv | 94 +++++++++
 tb/tb_sram_arbiter.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/sram_arbiter_if.sv
// sram_arbiter_if: engine-side request/grant bus plus the SRAM port of sram_arbiter
interface sram_arbiter_if #(
  parameter int NUM_CH = 2,
  parameter int DATA_W = 1536,
  parameter int ADDR_W = 24
);
  logic [NUM_CH-1:0] ch_req;
  logic [NUM_CH-1:0] ch_wr;
  logic [NUM_CH*ADDR_W-1:0] ch_addr;
  logic [NUM_CH*DATA_W-1:0] ch_wdata;
  logic [NUM_CH-1:0] ch_gnt;
  logic [NUM_CH-1:0] ch_rvalid;
  logic [DATA_W-1:0] ch_rdata;
  logic [DATA_W-1:0] read_data;
  logic read_enable;
  logic write_enable;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] write_data;
  modport slave (
    input ch_req, ch_wr, ch_addr, ch_wdata, read_data,
    output ch_gnt, ch_rvalid, ch_rdata, read_enable, write_enable, address, write_data
  );
  modport master (
    output ch_req, ch_wr, ch_addr, ch_wdata, read_data,
    input ch_gnt, ch_rvalid, ch_rdata, read_enable, write_enable, address, write_data
  );
endinterface

// File: rtl/sram_arbiter.sv
// sram_arbiter: round-robin burst arbiter of NUM_CH engines onto one SRAM port; SRAM_ARBITER_PRIORITY_EN gives channel 0 fixed priority
module sram_arbiter #(
  parameter int NUM_CH = 2,
  parameter int DATA_W = 1536,
  parameter int ADDR_W = 24,
  parameter int MAX_BURST = 16
) (
  input logic clk,
  input logic rst,
  sram_arbiter_if.slave bus
);
  localparam int IW = $clog2(NUM_CH);
  localparam int CW = $clog2(MAX_BURST + 1);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state_q, state_d;
  logic [IW-1:0] rr_q, rr_d, gidx_q, gidx_d, win, idx;
  logic [CW-1:0] cnt_q, cnt_d;
  logic re_q, re_d, we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [NUM_CH-1:0] tag_q, tag_d, rv_q, gnt;
  logic accept;
  assign gnt = (state_q == BUSY) ? NUM_CH'(1) << gidx_q : '0;
  assign accept = (state_q == BUSY) && bus.ch_req[gidx_q];
  // scan downward so the requester closest above rr_q is written last and wins
  always_comb begin
    win = rr_q;
    idx = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      idx = IW'((int'(rr_q) + k) % NUM_CH);
      if (bus.ch_req[idx]) win = idx;
    end
`ifdef SRAM_ARBITER_PRIORITY_EN
    if (bus.ch_req[0]) win = '0;
`endif
  end
  always_comb begin
    state_d = state_q;
    rr_d = rr_q;
    gidx_d = gidx_q;
    cnt_d = cnt_q;
    if (state_q == IDLE) begin
      if (|bus.ch_req) begin
        state_d = BUSY;
        gidx_d = win;
        cnt_d = '0;
      end
    end else if (!accept || cnt_q == CW'(MAX_BURST - 1)) begin
      state_d = IDLE;
      rr_d = (gidx_q == IW'(NUM_CH - 1)) ? '0 : gidx_q + 1'b1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end
  // read tags travel apart from the FSM so releases never drop in-flight reads
  always_comb begin
    re_d = accept & ~bus.ch_wr[gidx_q];
    we_d = accept & bus.ch_wr[gidx_q];
    addr_d = accept ? bus.ch_addr[int'(gidx_q) * ADDR_W +: ADDR_W] : addr_q;
    wdata_d = accept ? bus.ch_wdata[int'(gidx_q) * DATA_W +: DATA_W] : wdata_q;
    tag_d = re_d ? gnt : '0;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      rr_q <= '0;
      gidx_q <= '0;
      cnt_q <= '0;
      re_q <= 1'b0;
      we_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      tag_q <= '0;
      rv_q <= '0;
    end else begin
      state_q <= state_d;
      rr_q <= rr_d;
      gidx_q <= gidx_d;
      cnt_q <= cnt_d;
      re_q <= re_d;
      we_q <= we_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      tag_q <= tag_d;
      rv_q <= tag_q;
    end
  assign bus.ch_gnt = gnt;
  assign bus.ch_rvalid = rv_q;
  assign bus.ch_rdata = (|rv_q) ? bus.read_data : '0;
  assign bus.read_enable = re_q;
  assign bus.write_enable = we_q;
  assign bus.address = addr_q;
  assign bus.write_data = wdata_q;
endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed checks of sram_arbiter with NUM_CH=2, MAX_BURST=4; honours SRAM_ARBITER_PRIORITY_EN
module tb_sram_arbiter;
  localparam int NC = 2;
  localparam int DW = 1536;
  localparam int AW = 24;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int tests = 0;
  int fails = 0;
  logic [1:0] exp_g [11];
  logic exp_we [11];
  logic [AW-1:0] burst2_addr;
  logic [DW-1:0] pat;
  always #5 clk = ~clk;
  sram_arbiter_if #(.NUM_CH(NC), .DATA_W(DW), .ADDR_W(AW)) bus ();
  sram_arbiter #(.NUM_CH(NC), .DATA_W(DW), .ADDR_W(AW), .MAX_BURST(4)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic chkw(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed low64 %0h expected low64 %0h, %0d bits differ", tag, obs[63:0], exp[63:0], $countones(obs ^ exp));
    end
  endtask
  initial begin
`ifdef SRAM_ARBITER_PRIORITY_EN
    exp_g = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b00, 2'b01, 2'b01, 2'b01, 2'b01, 2'b00, 2'b01};
    burst2_addr = 24'h000100;
`else
    exp_g = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b10, 2'b10, 2'b00, 2'b01};
    burst2_addr = 24'h000200;
`endif
    exp_we = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    pat = {64{24'h000010}};
    bus.ch_req = '0;
    bus.ch_wr = '0;
    bus.ch_addr = '0;
    bus.ch_wdata = '0;
    bus.read_data = '1;
    tick;
    chk("rst_gnt", bus.ch_gnt, 0);
    chk("rst_rvalid", bus.ch_rvalid, 0);
    chk("rst_re", bus.read_enable, 0);
    chk("rst_we", bus.write_enable, 0);
    chk("rst_addr", bus.address, 0);
    chkw("rst_wdata", bus.write_data, '0);
    chkw("rst_rdata", bus.ch_rdata, '0);
    tick;
    rst = 1'b0;
    bus.read_data = '0;
    bus.ch_wr = 2'b11;
    bus.ch_addr = {24'h000200, 24'h000100};
    bus.ch_req = 2'b11;
    for (int i = 0; i < 11; i++) begin
      tick;
      chk($sformatf("burst_gnt%0d", i), bus.ch_gnt, exp_g[i]);
      chk($sformatf("burst_we%0d", i), bus.write_enable, exp_we[i]);
      if (i == 4) chk("burst1_addr", bus.address, 24'h000100);
      if (i == 9) chk("burst2_addr", bus.address, burst2_addr);
    end
    bus.ch_req = 2'b00;
    tick;
    chk("drop_gnt", bus.ch_gnt, 0);
    chk("drop_we", bus.write_enable, 0);
    chk("drop_addr_hold", bus.address, burst2_addr);
    chk("drop_rr", dut.rr_q, 1);
    bus.ch_wr = 2'b00;
    bus.ch_addr[0 +: AW] = 24'h000010;
    bus.ch_req = 2'b01;
    tick;
    chk("rd_gnt", bus.ch_gnt, 2'b01);
    chk("rd_re_before", bus.read_enable, 0);
    tick;
    bus.ch_req = 2'b00;
    chk("rd_re", bus.read_enable, 1);
    chk("rd_addr", bus.address, 24'h000010);
    chk("rd_we", bus.write_enable, 0);
    chk("rd_rvalid_early", bus.ch_rvalid, 0);
    tick;
    bus.read_data = pat;
    #1;
    chk("rd_rvalid", bus.ch_rvalid, 2'b01);
    chkw("rd_rdata", bus.ch_rdata, pat);
    chk("rd_re_after", bus.read_enable, 0);
    chk("rd_gnt_after", bus.ch_gnt, 0);
    tick;
    chk("rd_rvalid_done", bus.ch_rvalid, 0);
    chkw("rd_rdata_done", bus.ch_rdata, '0);
    bus.ch_wr = 2'b10;
    bus.ch_addr[AW +: AW] = 24'h0000FF;
    bus.ch_wdata[DW +: DW] = '1;
    bus.ch_req = 2'b10;
    tick;
    chk("wr_gnt", bus.ch_gnt, 2'b10);
    chk("wr_we_before", bus.write_enable, 0);
    for (int i = 0; i < 3; i++) begin
      tick;
      chk($sformatf("wr_we%0d", i), bus.write_enable, 1);
      chk($sformatf("wr_addr%0d", i), bus.address, 24'h0000FF);
      chkw($sformatf("wr_wdata%0d", i), bus.write_data, '1);
    end
    bus.ch_req = 2'b00;
    tick;
    chk("wr_we_end", bus.write_enable, 0);
    chk("wr_gnt_end", bus.ch_gnt, 0);
    chk("wr_state_idle", dut.state_q, 0);
    chk("wr_rr", dut.rr_q, 0);
    bus.ch_wr = 2'b00;
    bus.ch_addr[0 +: AW] = 24'h000020;
    bus.ch_req = 2'b01;
    tick;
    tick;
    tick;
    chk("inflight_rvalid", bus.ch_rvalid, 2'b01);
    bus.read_data = '1;
    rst = 1'b1;
    #1;
    chk("mid_rst_gnt", bus.ch_gnt, 0);
    chk("mid_rst_rvalid", bus.ch_rvalid, 0);
    chk("mid_rst_re", bus.read_enable, 0);
    chk("mid_rst_we", bus.write_enable, 0);
    chk("mid_rst_addr", bus.address, 0);
    chkw("mid_rst_wdata", bus.write_data, '0);
    chkw("mid_rst_rdata", bus.ch_rdata, '0);
    chk("mid_rst_rr", dut.rr_q, 0);
    bus.ch_req = 2'b00;
    tick;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk($sformatf("post_rst_rvalid%0d", i), bus.ch_rvalid, 0);
      chk($sformatf("post_rst_re%0d", i), bus.read_enable, 0);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
